sss_subcarrier_mapper: RTL and testbench

Downstream stage of the SSS generator. Captures the 62-bit secondary synchronisation sequence and streams it as one 72-subcarrier OFDM symbol. The stream is 5 zero guard subcarriers, then 62 BPSK-modulated sequence elements, then 5 zero guard subcarriers. Output uses a valid/ready handshake and feeds the resource-grid / IFFT input buffer.

---
 rtl/sss_subcarrier_mapper.sv | 125 ++++++++++++
 tb/tb_sss_subcarrier_mapper.sv | 366 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sss_subcarrier_mapper.sv
// sss_subcarrier_mapper
// Captures a 62-element SSS sequence and streams it as one 72-subcarrier OFDM
// symbol: 5 zero guards, 62 BPSK samples (d = 1 - 2s), 5 zero guards.
// The output side is a valid/ready stream. Every output is driven from a flop.
module sss_subcarrier_mapper #(
    parameter int AMP_WIDTH = 16,
    parameter int AMPLITUDE = 8192
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [61:0]                 sss,
    input  logic                        sss_load,
    input  logic                        out_ready,
    output logic                        sym_valid,
    output logic signed [AMP_WIDTH-1:0] sym_i,
    output logic signed [AMP_WIDTH-1:0] sym_q,
    output logic [6:0]                  sym_index,
    output logic                        sym_last,
    output logic                        busy
);

    localparam logic signed [AMP_WIDTH-1:0] AMP_POS = AMP_WIDTH'(AMPLITUDE);

    // Index of the last sample in each region of the symbol
    localparam logic [6:0] LAST_GUARD_LO = 7'd4;
    localparam logic [6:0] LAST_DATA     = 7'd66;
    localparam logic [6:0] PRE_LAST      = 7'd70;
    localparam logic [6:0] LAST_IDX      = 7'd71;

    typedef enum logic [1:0] {
        IDLE,
        GUARD_LO,
        DATA,
        GUARD_HI
    } state_t;

    state_t      state;
    logic [61:0] shadow;
    logic [5:0]  elem_cnt;   // next sequence element to present
    logic        xfer;

    // A sample leaves the block on any edge where it is offered and accepted
    assign xfer = sym_valid & out_ready;

    // BPSK mapping of one sequence bit: 0 -> +A, 1 -> -A
    function automatic logic signed [AMP_WIDTH-1:0] bpsk_map(input logic s);
        return s ? -AMP_POS : AMP_POS;
    endfunction

    // Symbol sequencer: advances one subcarrier per transfer and registers the
    // sample for the following cycle, so outputs hold while out_ready is low
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            shadow    <= '0;
            elem_cnt  <= '0;
            sym_valid <= 1'b0;
            sym_i     <= '0;
            sym_q     <= '0;
            sym_index <= '0;
            sym_last  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            sym_q <= '0;
            case (state)
                IDLE: begin
                    if (sss_load) begin
                        shadow    <= sss;
                        elem_cnt  <= '0;
                        sym_index <= '0;
                        sym_i     <= '0;
                        sym_last  <= 1'b0;
                        sym_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= GUARD_LO;
                    end
                end
                GUARD_LO: begin
                    if (xfer) begin
                        sym_index <= sym_index + 7'd1;
                        if (sym_index == LAST_GUARD_LO) begin
                            sym_i    <= bpsk_map(shadow[elem_cnt]);
                            elem_cnt <= elem_cnt + 6'd1;
                            state    <= DATA;
                        end
                    end
                end
                DATA: begin
                    if (xfer) begin
                        sym_index <= sym_index + 7'd1;
                        if (sym_index == LAST_DATA) begin
                            sym_i <= '0;
                            state <= GUARD_HI;
                        end else begin
                            sym_i    <= bpsk_map(shadow[elem_cnt]);
                            elem_cnt <= elem_cnt + 6'd1;
                        end
                    end
                end
                GUARD_HI: begin
                    if (xfer) begin
                        if (sym_index == LAST_IDX) begin
                            // Loads arriving with the final transfer are dropped:
                            // busy is still high during that cycle
                            sym_valid <= 1'b0;
                            busy      <= 1'b0;
                            sym_index <= '0;
                            sym_last  <= 1'b0;
                            state     <= IDLE;
                        end else begin
                            sym_index <= sym_index + 7'd1;
                            sym_last  <= (sym_index == PRE_LAST);
                        end
                    end
                end
                default: begin
                    state     <= IDLE;
                    sym_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sss_subcarrier_mapper.sv
// Testbench for sss_subcarrier_mapper: expected samples are queued at load
// time and popped by a monitor whenever the DUT transfers a sample.
module tb_sss_subcarrier_mapper;

    localparam int AMP = 8192;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [61:0]        sss = '0;
    logic               sss_load = 1'b0;
    logic               out_ready = 1'b1;
    logic               sym_valid;
    logic signed [15:0] sym_i;
    logic signed [15:0] sym_q;
    logic [6:0]         sym_index;
    logic               sym_last;
    logic               busy;

    int checks = 0;
    int failures = 0;
    int n_xfer = 0;

    typedef struct packed {
        logic [15:0] i;
        logic [6:0]  idx;
        logic        last;
    } exp_t;

    exp_t exp_q[$];

    logic        hold_vld = 1'b0;
    logic [15:0] hold_i;
    logic [6:0]  hold_idx;
    logic        hold_last;

    sss_subcarrier_mapper #(
        .AMP_WIDTH(16),
        .AMPLITUDE(AMP)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .sss       (sss),
        .sss_load  (sss_load),
        .out_ready (out_ready),
        .sym_valid (sym_valid),
        .sym_i     (sym_i),
        .sym_q     (sym_q),
        .sym_index (sym_index),
        .sym_last  (sym_last),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // LTE SSS (subframe 0, N_ID_1 = 0) as bits s, where d(n) = 1 - 2*s(n)
    function automatic logic [61:0] gen_sss(input int n2);
        logic [30:0] xs, xc, xz;
        logic [61:0] d;
        int m0, m1;
        m0 = 0;
        m1 = 1;
        xs = '0; xc = '0; xz = '0;
        xs[4] = 1'b1; xc[4] = 1'b1; xz[4] = 1'b1;
        for (int i = 0; i < 26; i++) begin
            xs[i+5] = xs[i+2] ^ xs[i];
            xc[i+5] = xc[i+3] ^ xc[i];
            xz[i+5] = xz[i+4] ^ xz[i+2] ^ xz[i+1] ^ xz[i];
        end
        for (int n = 0; n < 31; n++) begin
            d[2*n]   = xs[(n+m0)%31] ^ xc[(n+n2)%31];
            d[2*n+1] = xs[(n+m1)%31] ^ xc[(n+n2+3)%31] ^ xz[(n+(m0%8))%31];
        end
        return d;
    endfunction

    task automatic push_expected(input logic [61:0] pat);
        exp_t e;
        for (int k = 0; k < 72; k++) begin
            int v;
            if (k >= 5 && k <= 66) v = pat[k-5] ? -AMP : AMP;
            else v = 0;
            e.i = v[15:0];
            e.idx = k[6:0];
            e.last = (k == 71);
            exp_q.push_back(e);
        end
    endtask

    // Drive a one-cycle load; returns one step after the capturing edge E0
    task automatic do_load(input logic [61:0] pat);
        @(posedge clk); #1;
        sss = pat;
        sss_load = 1'b1;
        push_expected(pat);
        @(posedge clk); #1;
        sss_load = 1'b0;
    endtask

    task automatic wait_idle(input bit rand_ready);
        bit done;
        done = 1'b0;
        for (int c = 0; c < 1000 && !done; c++) begin
            @(posedge clk); #1;
            if (rand_ready) out_ready = ($urandom_range(0, 2) != 0);
            if (!busy) done = 1'b1;
        end
        out_ready = 1'b1;
        checks++;
        if (!done) begin
            failures++;
            $display("FAIL wait_idle: busy=%0b still high, required 0 within budget", busy);
        end
    endtask

    // Monitor: pop/compare on every transfer, and check stability while stalled
    always @(negedge clk) begin
        if (reset) begin
            hold_vld = 1'b0;
        end else begin
            if (hold_vld) begin
                checks++;
                if (sym_valid !== 1'b1 || sym_i !== hold_i || sym_index !== hold_idx || sym_last !== hold_last) begin
                    failures++;
                    $display("FAIL stall_hold: got v=%0b i=%0d idx=%0d last=%0b, required v=1 i=%0d idx=%0d last=%0b",
                             sym_valid, sym_i, sym_index, sym_last, $signed(hold_i), hold_idx, hold_last);
                end
            end
            if (sym_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_sample: got i=%0d idx=%0d, required no sample", sym_i, sym_index);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    if (sym_i !== e.i || sym_q !== 16'sd0 || sym_index !== e.idx || sym_last !== e.last) begin
                        failures++;
                        $display("FAIL sample: got i=%0d q=%0d idx=%0d last=%0b, required i=%0d q=0 idx=%0d last=%0b",
                                 sym_i, sym_q, sym_index, sym_last, $signed(e.i), e.idx, e.last);
                    end
                end
                n_xfer++;
                hold_vld = 1'b0;
            end else if (sym_valid) begin
                hold_vld = 1'b1;
                hold_i = sym_i;
                hold_idx = sym_index;
                hold_last = sym_last;
            end else begin
                hold_vld = 1'b0;
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        #1;
        checks++;
        if (sym_valid !== 1'b0 || busy !== 1'b0 || sym_last !== 1'b0 || sym_i !== 16'sd0 || sym_q !== 16'sd0 || sym_index !== 7'd0) begin
            failures++;
            $display("FAIL reset_values: got v=%0b busy=%0b last=%0b i=%0d q=%0d idx=%0d, required all 0",
                     sym_valid, busy, sym_last, sym_i, sym_q, sym_index);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_zero_timing();
        int x0;
        x0 = n_xfer;
        out_ready = 1'b1;
        do_load(62'h0);
        checks++;
        if (sym_valid !== 1'b1 || busy !== 1'b1 || sym_index !== 7'd0) begin
            failures++;
            $display("FAIL load_latency: got v=%0b busy=%0b idx=%0d, required v=1 busy=1 idx=0", sym_valid, busy, sym_index);
        end
        repeat (71) @(posedge clk);
        #1;
        checks++;
        if (sym_last !== 1'b1 || sym_index !== 7'd71 || busy !== 1'b1) begin
            failures++;
            $display("FAIL last_at_E71: got last=%0b idx=%0d busy=%0b, required 1 71 1", sym_last, sym_index, busy);
        end
        @(posedge clk); #1;
        checks++;
        if (busy !== 1'b0 || sym_valid !== 1'b0) begin
            failures++;
            $display("FAIL idle_after_E72: got busy=%0b v=%0b, required 0 0", busy, sym_valid);
        end
        checks++;
        if (exp_q.size() != 0 || n_xfer - x0 != 72) begin
            failures++;
            $display("FAIL zero_count: got left=%0d xfers=%0d, required 0 72", exp_q.size(), n_xfer - x0);
        end
    endtask

    task automatic test_generator(input int n2);
        int x0;
        x0 = n_xfer;
        do_load(gen_sss(n2));
        wait_idle(1'b0);
        checks++;
        if (exp_q.size() != 0 || n_xfer - x0 != 72) begin
            failures++;
            $display("FAIL gen_n2_%0d: got left=%0d xfers=%0d, required 0 72", n2, exp_q.size(), n_xfer - x0);
        end
    endtask

    task automatic test_backpressure();
        int x0;
        x0 = n_xfer;
        do_load(gen_sss(5));
        wait_idle(1'b1);
        checks++;
        if (exp_q.size() != 0 || n_xfer - x0 != 72) begin
            failures++;
            $display("FAIL backpressure: got left=%0d xfers=%0d, required 0 72", exp_q.size(), n_xfer - x0);
        end
    endtask

    task automatic test_ignore_mid();
        logic [61:0] pat;
        bit hit;
        pat = gen_sss(2);
        do_load(pat);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (sym_index == 7'd30) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reach_idx30: got idx=%0d, required 30", sym_index);
        end
        sss = ~pat;
        sss_load = 1'b1;
        @(posedge clk); #1;
        sss_load = 1'b0;
        checks++;
        if (busy !== 1'b1) begin
            failures++;
            $display("FAIL busy_mid: got %0b, required 1", busy);
        end
        wait_idle(1'b0);
        repeat (5) @(posedge clk);
        #1;
        checks++;
        if (sym_valid !== 1'b0 || exp_q.size() != 0) begin
            failures++;
            $display("FAIL ignore_mid: got v=%0b left=%0d, required 0 0", sym_valid, exp_q.size());
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        bit bad;
        do_load(gen_sss(5));
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (sym_index == 7'd40) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reach_idx40: got idx=%0d, required 40", sym_index);
        end
        reset = 1'b1;
        #1;
        checks++;
        if (sym_valid !== 1'b0 || busy !== 1'b0 || sym_last !== 1'b0 || sym_i !== 16'sd0 || sym_q !== 16'sd0 || sym_index !== 7'd0) begin
            failures++;
            $display("FAIL reset_mid: got v=%0b busy=%0b i=%0d idx=%0d, required all 0", sym_valid, busy, sym_i, sym_index);
        end
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        bad = 1'b0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            if (sym_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
        end
        checks++;
        if (bad) begin
            failures++;
            $display("FAIL quiet_after_reset: got v=%0b busy=%0b, required 0 0", sym_valid, busy);
        end
        do_load(gen_sss(2));
        checks++;
        if (sym_valid !== 1'b1 || sym_index !== 7'd0) begin
            failures++;
            $display("FAIL restart_idx: got v=%0b idx=%0d, required 1 0", sym_valid, sym_index);
        end
        wait_idle(1'b0);
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL restart_left: got %0d, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        logic [61:0] pa, pb;
        bit hit;
        int x0;
        x0 = n_xfer;
        pa = gen_sss(5);
        pb = 62'h2AAA_5555_F0F0_0F0F;
        out_ready = 1'b1;
        do_load(pa);
        hit = 1'b0;
        for (int c = 0; c < 200 && !hit; c++) begin
            if (sym_last === 1'b1) hit = 1'b1;
            else begin @(posedge clk); #1; end
        end
        checks++;
        if (!hit) begin
            failures++;
            $display("FAIL reach_last: got last=%0b, required 1", sym_last);
        end
        // Load during the final transfer must be dropped
        sss = ~pa;
        sss_load = 1'b1;
        @(posedge clk); #1;
        sss_load = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL b2b_gap: got busy=%0b, required 0", busy);
        end
        sss = pb;
        sss_load = 1'b1;
        push_expected(pb);
        @(posedge clk); #1;
        sss_load = 1'b0;
        checks++;
        if (sym_valid !== 1'b1 || sym_index !== 7'd0 || sym_i !== 16'sd0) begin
            failures++;
            $display("FAIL b2b_start: got v=%0b idx=%0d i=%0d, required 1 0 0", sym_valid, sym_index, sym_i);
        end
        wait_idle(1'b0);
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0 || n_xfer - x0 != 144 || sym_valid !== 1'b0) begin
            failures++;
            $display("FAIL b2b_count: got left=%0d xfers=%0d v=%0b, required 0 144 0", exp_q.size(), n_xfer - x0, sym_valid);
        end
    endtask

    initial begin
        test_reset();
        test_zero_timing();
        test_generator(5);
        test_generator(2);
        test_backpressure();
        test_ignore_mid();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
